// File: rtl/int_arb_pkg.sv
// -----------------------------------------------------------------------------
// int_arb_pkg
//   Shared types and helpers for the interrupt arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, ASSERT, SERVICE)
//   - SYNC_STAGES : metastability flops in front of the edge detector
//   - lowest_id   : index of the lowest set bit of a 32-bit vector
// -----------------------------------------------------------------------------
package int_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } arb_state_e;

    localparam int SYNC_STAGES = 2;

    // Scans from the top down so that the last hit kept is the lowest index.
    // Returns 0 for an all-zero vector; callers only use it when some bit is set.
    function automatic logic [4:0] lowest_id(input logic [31:0] vec);
        logic [4:0] id;
        id = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            id = vec[i] ? 5'(i) : id;
        end
        return id;
    endfunction

endpackage

// File: rtl/int_arbiter_edge_sync.sv
// -----------------------------------------------------------------------------
// int_edge_sync
//   Synchroniser plus rising-edge detector for one asynchronous level input.
//   A rise first sampled at edge k produces a one-cycle d_edge pulse between
//   edges k+1 and k+2.
// Ports
//   clk    : core clock
//   rst    : synchronous active-high reset
//   d      : asynchronous level input
//   d_edge : one-cycle pulse on a synchronised 0->1 transition
//            ('edge' is a reserved word, hence the name)
// -----------------------------------------------------------------------------
module int_edge_sync
    import int_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic d_edge
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain followed by the previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign d_edge = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/int_arbiter.sv
// -----------------------------------------------------------------------------
// int_arbiter
//   Multi-source interrupt arbiter driving the CPU global interrupt line.
//   Each source is synchronised and edge-detected, latched as pending, and
//   the enabled pending sources are arbitrated on a claim. A claim/complete
//   handshake tells the handler which source fired and holds g_interrupt low
//   until the handler signals completion of that same id.
//
//   Build option INT_ARB_RR_EN:
//     defined   - round-robin search starting after the last granted id
//     undefined - fixed priority, lowest index wins (no pointer register)
//
// Ports
//   clk          : core clock
//   rst          : synchronous active-high reset
//   int_src      : raw asynchronous level interrupt inputs
//   int_en       : per-source enable mask
//   csr_meie     : machine external interrupt enable
//   claim_req    : one-cycle claim read pulse
//   claim_ack    : one-cycle pulse, one cycle after every claim_req
//   claim_valid  : 1 when claim_id holds a freshly granted source
//   claim_id     : granted source id, held until the next grant
//   complete_req : one-cycle completion write pulse
//   complete_id  : id written with complete_req
//   g_interrupt  : registered interrupt request to the core
//   pending      : pending bits (status)
// -----------------------------------------------------------------------------
module int_arbiter
    import int_arb_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [NUM_SRC-1:0] int_en,
    input  logic               csr_meie,
    input  logic               claim_req,
    output logic               claim_ack,
    output logic               claim_valid,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_req,
    input  logic [ID_W-1:0]    complete_id,
    output logic               g_interrupt,
    output logic [NUM_SRC-1:0] pending
);

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic               g_int_r;
    logic               g_nxt_s;
    logic               claim_ack_r;
    logic               claim_valid_r;
    logic [ID_W-1:0]    claim_id_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] edge_vec_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] clr_mask_s;
    logic [ID_W-1:0]    winner_s;
    logic               grant_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_sync
            int_edge_sync u_sync (
                .clk    (clk),
                .rst    (rst),
                .d      (int_src[gi]),
                .d_edge (edge_vec_s[gi])
            );
        end
    endgenerate

    assign eligible_s = csr_meie ? (pending_r & int_en) : {NUM_SRC{1'b0}};

`ifdef INT_ARB_RR_EN
    logic [ID_W-1:0] last_r;
    logic            rr_found_s;

    // Round-robin pick: first eligible id after the last grant, wrapping to 0.
    always_comb begin
        winner_s   = {ID_W{1'b0}};
        rr_found_s = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            int idx;
            idx        = (int'(last_r) + i) % NUM_SRC;
            winner_s   = (!rr_found_s && eligible_s[idx]) ? ID_W'(idx) : winner_s;
            rr_found_s = rr_found_s | eligible_s[idx];
        end
    end

    // Pointer moves only on a valid grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= {ID_W{1'b0}};
        end else if (grant_s) begin
            last_r <= winner_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    logic [31:0] elig32_s;

    // Fixed-priority pick: the lowest eligible index.
    always_comb begin
        elig32_s              = 32'd0;
        elig32_s[NUM_SRC-1:0] = eligible_s;
        winner_s              = ID_W'(lowest_id(elig32_s));
    end
`endif

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        state_nxt_s = state_r;
        g_nxt_s     = g_int_r;
        grant_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (|eligible_s) begin
                    state_nxt_s = ASSERT;
                    g_nxt_s     = 1'b1;
                end else begin
                    g_nxt_s     = 1'b0;
                end
            end
            ASSERT: begin
                // Losing all eligible sources wins over a simultaneous claim:
                // there is nothing to grant, so the claim returns valid=0.
                if (!(|eligible_s)) begin
                    state_nxt_s = IDLE;
                    g_nxt_s     = 1'b0;
                end else if (claim_req) begin
                    grant_s     = 1'b1;
                    state_nxt_s = SERVICE;
                    g_nxt_s     = 1'b0;
                end else begin
                    g_nxt_s     = 1'b1;
                end
            end
            SERVICE: begin
                g_nxt_s = 1'b0;
                if (complete_req && (complete_id == claim_id_r)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVICE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                g_nxt_s     = 1'b0;
            end
        endcase
    end

    // One-hot clear for the granted source.
    always_comb begin
        clr_mask_s           = {NUM_SRC{1'b0}};
        clr_mask_s[winner_s] = grant_s;
    end

    // State, handshake outputs and pending bits; a new edge overrides a grant clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            g_int_r       <= 1'b0;
            claim_ack_r   <= 1'b0;
            claim_valid_r <= 1'b0;
            claim_id_r    <= {ID_W{1'b0}};
            pending_r     <= {NUM_SRC{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            g_int_r       <= g_nxt_s;
            claim_ack_r   <= claim_req;
            claim_valid_r <= grant_s;
            claim_id_r    <= grant_s ? winner_s : claim_id_r;
            pending_r     <= (pending_r & ~clr_mask_s) | edge_vec_s;
        end
    end

    assign g_interrupt = g_int_r;
    assign claim_ack   = claim_ack_r;
    assign claim_valid = claim_valid_r;
    assign claim_id    = claim_id_r;
    assign pending     = pending_r;

endmodule

// File: tb/tb_int_arbiter.sv
// -----------------------------------------------------------------------------
// tb_int_arbiter
//   Self-checking bench for int_arbiter (NUM_SRC=8). Expected claim results
//   are queued when a claim is driven and compared when claim_ack appears.
//   Define INT_ARB_RR_EN for both RTL and bench to exercise round-robin.
// -----------------------------------------------------------------------------
module tb_int_arbiter;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

`ifdef INT_ARB_RR_EN
    localparam logic [ID_W-1:0] T2_FIRST  = 3'd5;
    localparam logic [ID_W-1:0] T2_SECOND = 3'd1;
`else
    localparam logic [ID_W-1:0] T2_FIRST  = 3'd1;
    localparam logic [ID_W-1:0] T2_SECOND = 3'd5;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] int_src;
    logic [NUM_SRC-1:0] int_en;
    logic               csr_meie;
    logic               claim_req;
    logic               claim_ack;
    logic               claim_valid;
    logic [ID_W-1:0]    claim_id;
    logic               complete_req;
    logic [ID_W-1:0]    complete_id;
    logic               g_interrupt;
    logic [NUM_SRC-1:0] pending;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [ID_W:0]   sb_q[$];
    logic [ID_W:0]   mon_exp;
    logic [ID_W-1:0] last_id;

    int_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .int_src      (int_src),
        .int_en       (int_en),
        .csr_meie     (csr_meie),
        .claim_req    (claim_req),
        .claim_ack    (claim_ack),
        .claim_valid  (claim_valid),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .g_interrupt  (g_interrupt),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a claim pulse and queue the expected result ({valid, id}).
    task automatic claim(input logic v, input logic [ID_W-1:0] id);
        if (v) last_id = id;
        sb_q.push_back({v, last_id});
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
    endtask

    task automatic complete(input logic [ID_W-1:0] id);
        complete_req = 1'b1;
        complete_id  = id;
        tick();
        complete_req = 1'b0;
    endtask

    // Raise sources long enough for pending to be set, then drop them.
    task automatic pulse_src(input logic [NUM_SRC-1:0] mask);
        int_src = int_src | mask;
        repeat (3) tick();
        int_src = int_src & ~mask;
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (g_interrupt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(g_interrupt), 32'd1);
    endtask

    // Scoreboard consumer: every claim_ack pops one expected claim result.
    always @(negedge clk) begin
        if (claim_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("ack_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_eq("claim_valid", 32'(claim_valid), 32'(mon_exp[ID_W]));
                check_eq("claim_id", 32'(claim_id), 32'(mon_exp[ID_W-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        int_src      = 8'h00;
        int_en       = 8'hFF;
        csr_meie     = 1'b1;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = 3'd0;
        last_id      = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_irq",   32'(g_interrupt), 32'd0);
        check_eq("rst_pend",  32'(pending),     32'd0);
        check_eq("rst_ack",   32'(claim_ack),   32'd0);
        check_eq("rst_valid", 32'(claim_valid), 32'd0);
        check_eq("rst_id",    32'(claim_id),    32'd0);

        // 1: latency of a single source through to claim
        int_src[3] = 1'b1;
        tick();
        check_eq("t1_pend_k",  32'(pending), 32'h00);
        tick();
        check_eq("t1_pend_k1", 32'(pending), 32'h00);
        tick();
        check_eq("t1_pend_k2", 32'(pending), 32'h08);
        check_eq("t1_irq_k2",  32'(g_interrupt), 32'd0);
        tick();
        check_eq("t1_irq_k3",  32'(g_interrupt), 32'd1);
        int_src[3] = 1'b0;
        claim(1'b1, 3'd3);
        check_eq("t1_irq_claimed",  32'(g_interrupt), 32'd0);
        check_eq("t1_pend_claimed", 32'(pending), 32'h00);
        complete(3'd3);

        // 2: two simultaneous sources, arbitration order
        for (int r = 0; r < 2; r++) begin
            pulse_src(8'h22);
            check_eq("t2_pend", 32'(pending), 32'h22);
            wait_irq("t2_irq_a");
            claim(1'b1, T2_FIRST);
            complete(T2_FIRST);
            wait_irq("t2_irq_b");
            claim(1'b1, T2_SECOND);
            complete(T2_SECOND);
            check_eq("t2_pend_done", 32'(pending), 32'h00);
        end

        // 3: mismatched complete ignored, matching complete returns to IDLE
        pulse_src(8'h04);
        wait_irq("t3_irq");
        claim(1'b1, 3'd2);
        pulse_src(8'h40);
        check_eq("t3_pend_svc", 32'(pending), 32'h40);
        check_eq("t3_irq_svc",  32'(g_interrupt), 32'd0);
        complete(3'd4);
        check_eq("t3_irq_bad_cpl", 32'(g_interrupt), 32'd0);
        claim(1'b0, 3'd0);
        check_eq("t3_still_svc", 32'(g_interrupt), 32'd0);
        complete(3'd2);
        check_eq("t3_irq_idle", 32'(g_interrupt), 32'd0);
        tick();
        check_eq("t3_irq_next", 32'(g_interrupt), 32'd1);
        claim(1'b1, 3'd6);
        complete(3'd6);

        // 4: enable and meie gating
        int_en = 8'hFE;
        pulse_src(8'h01);
        check_eq("t4_pend", 32'(pending), 32'h01);
        tick();
        tick();
        check_eq("t4_en_off", 32'(g_interrupt), 32'd0);
        int_en   = 8'hFF;
        csr_meie = 1'b0;
        tick();
        tick();
        check_eq("t4_meie_off", 32'(g_interrupt), 32'd0);
        csr_meie = 1'b1;
        tick();
        check_eq("t4_en_on", 32'(g_interrupt), 32'd1);
        int_en = 8'hFE;
        tick();
        check_eq("t4_en_drop_irq",  32'(g_interrupt), 32'd0);
        check_eq("t4_en_drop_pend", 32'(pending), 32'h01);
        int_en = 8'hFF;
        wait_irq("t4_irq_again");
        claim(1'b1, 3'd0);
        complete(3'd0);

        // 5: new edge in the same cycle as the grant clear is kept
        pulse_src(8'h04);
        tick();
        wait_irq("t5_irq");
        int_src[2] = 1'b1;
        tick();
        tick();
        claim(1'b1, 3'd2);
        check_eq("t5_set_wins", 32'(pending), 32'h04);
        check_eq("t5_irq_svc",  32'(g_interrupt), 32'd0);
        int_src[2] = 1'b0;
        complete(3'd2);
        wait_irq("t5_irq_again");
        claim(1'b1, 3'd2);
        complete(3'd2);
        check_eq("t5_pend_done", 32'(pending), 32'h00);
        claim(1'b0, 3'd0);
        check_eq("t5_idle_irq", 32'(g_interrupt), 32'd0);

        // 6: reset in SERVICE drops the claim
        pulse_src(8'h10);
        wait_irq("t6_irq");
        claim(1'b1, 3'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_id = 3'd0;
        check_eq("t6_rst_irq",   32'(g_interrupt), 32'd0);
        check_eq("t6_rst_ack",   32'(claim_ack),   32'd0);
        check_eq("t6_rst_valid", 32'(claim_valid), 32'd0);
        check_eq("t6_rst_id",    32'(claim_id),    32'd0);
        check_eq("t6_rst_pend",  32'(pending),     32'd0);
        pulse_src(8'h80);
        wait_irq("t6_irq_after_rst");
        claim(1'b1, 3'd7);
        complete(3'd7);

        repeat (3) tick();
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
